// File: rtl/conv_window_3x3_pkg.sv
// Shared constants and helpers for the 3x3 sliding-window generator.
// Tap k of a window sits at flat bits [k*DATA_W +: DATA_W].
package conv_window_3x3_pkg;

  localparam int WIN_K      = 3;
  localparam int WIN_TAPS   = WIN_K * WIN_K;
  localparam int DATA_W_DEF = 8;

  function automatic int tap_idx(input int r, input int c);
    return WIN_K * r + c;
  endfunction

  function automatic int flat_w(input int dw);
    return WIN_TAPS * dw;
  endfunction

endpackage

// File: rtl/conv_window_3x3_if.sv
// Pixel-in / window-out handshake bundle of the window generator.
// master is the surrounding pipeline, slave is the generator.
interface conv_window_3x3_if
  import conv_window_3x3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);

  logic [DATA_W-1:0]         in_pixel;
  logic                      in_valid;
  logic                      in_sof;
  logic                      in_ready;
  logic [flat_w(DATA_W)-1:0] win_flat;
  logic                      out_valid;
  logic                      out_last;
  logic                      out_ready;

  modport master (
    output in_pixel, in_valid, in_sof, out_ready,
    input  in_ready, win_flat, out_valid, out_last
  );

  modport slave (
    input  in_pixel, in_valid, in_sof, out_ready,
    output in_ready, win_flat, out_valid, out_last
  );

endinterface

// File: rtl/conv_line_buffer.sv
// One image line of pixels, read-before-write at a single address.
// Contents are never cleared; the window logic gates stale data.
module conv_line_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_addr,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/conv_window_3x3.sv
// Streaming 3x3 window generator feeding the 3x3 MAC stage.
// Two line buffers plus a 3x3 tap shift register, one output register.
module conv_window_3x3
  import conv_window_3x3_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IMG_W  = 8,
  parameter int IMG_H  = 8
) (
  input logic             clk,
  input logic             rst,
  conv_window_3x3_if.slave s_if
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int FW = flat_w(DATA_W);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]     r_col;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     w_col;
  logic [RW-1:0]     w_row;
  logic              w_acc;
  logic              w_emit;
  logic [DATA_W-1:0] w_t0;
  logic [DATA_W-1:0] w_t1;
  logic [DATA_W-1:0] r_taps [WIN_TAPS];
  logic [DATA_W-1:0] w_taps [WIN_TAPS];
  logic [FW-1:0]     w_flat;
  logic [FW-1:0]     r_win;
  logic              r_valid;
  logic              r_last;

  assign s_if.in_ready = !r_valid || s_if.out_ready;
  assign w_acc = s_if.in_valid && s_if.in_ready;

  // sof forces the accepted pixel to (0,0) whatever the counters say
  assign w_col = s_if.in_sof ? '0 : r_col;
  assign w_row = s_if.in_sof ? '0 : r_row;

  assign w_emit = w_acc && (w_row >= ROW_TWO) && (w_col >= COL_TWO);

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb0 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (w_col),
    .i_wdata (s_if.in_pixel),
    .o_rdata (w_t1)
  );

  conv_line_buffer #(
    .DATA_W (DATA_W),
    .DEPTH  (IMG_W)
  ) u_lb1 (
    .clk     (clk),
    .i_we    (w_acc),
    .i_addr  (w_col),
    .i_wdata (w_t1),
    .o_rdata (w_t0)
  );

  always_comb begin
    w_taps = r_taps;
    w_flat = '0;
    for (int r = 0; r < WIN_K; r++) begin
      for (int c = 0; c < WIN_K - 1; c++) begin
        w_taps[tap_idx(r, c)] = r_taps[tap_idx(r, c + 1)];
      end
    end
    w_taps[tap_idx(0, 2)] = w_t0;
    w_taps[tap_idx(1, 2)] = w_t1;
    w_taps[tap_idx(2, 2)] = s_if.in_pixel;
    for (int k = 0; k < WIN_TAPS; k++) begin
      w_flat[k*DATA_W +: DATA_W] = w_taps[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < WIN_TAPS; k++) r_taps[k] <= '0;
    end else if (w_acc) begin
      r_taps <= w_taps;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      if (w_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
      end else begin
        r_col <= w_col + 1'b1;
        r_row <= w_row;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_win   <= '0;
    end else if (w_emit) begin
      r_valid <= 1'b1;
      r_win   <= w_flat;
      r_last  <= (w_row == ROW_LAST) && (w_col == COL_LAST);
    end else if (s_if.out_ready) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign s_if.win_flat  = r_win;
  assign s_if.out_valid = r_valid;
  assign s_if.out_last  = r_last;

endmodule

// File: tb/tb_conv_window_3x3.sv
// Scoreboard bench for conv_window_3x3 on a 5x4 image.
// Driver queues expected windows; a negedge monitor pops and compares.
module tb_conv_window_3x3;
  import conv_window_3x3_pkg::*;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int H  = 4;
  localparam int FW = WIN_TAPS * DW;

  typedef struct packed {
    logic [FW-1:0] win;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_3x3_if #(.DATA_W(DW)) ifc ();

  conv_window_3x3 #(
    .DATA_W (DW),
    .IMG_W  (W),
    .IMG_H  (H)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_if (ifc.slave)
  );

  exp_t exp_q[$];
  exp_t got_q[$];
  int   n_chk = 0;
  int   n_pass = 0;
  bit   rnd_ready = 1'b0;

  task automatic chk(string nm, logic [FW-1:0] act, logic [FW-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", nm, act, req);
  endtask

  function automatic logic [FW-1:0] pk(
    input int a0, input int a1, input int a2,
    input int a3, input int a4, input int a5,
    input int a6, input int a7, input int a8);
    return {DW'(a8), DW'(a7), DW'(a6), DW'(a5), DW'(a4),
            DW'(a3), DW'(a2), DW'(a1), DW'(a0)};
  endfunction

  // Window at (r,c) of a frame whose pixel (y,x) is base + W*y + x
  function automatic logic [FW-1:0] model(input int base, input int r,
                                          input int c);
    logic [FW-1:0] res;
    res = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        res[(3*i+j)*DW +: DW] = DW'(base + W*(r-2+i) + (c-2+j));
    return res;
  endfunction

  function automatic int sum9(input logic [FW-1:0] w);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) s += int'(w[k*DW +: DW]);
    return s;
  endfunction

  initial begin
    ifc.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ifc.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    bit            pst;
    logic [FW-1:0] pw;
    logic          pl;
    exp_t          e;
    pst = 1'b0;
    pw  = '0;
    pl  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pst = 1'b0;
        continue;
      end
      if (pst) begin
        chk("hold_valid", FW'(ifc.out_valid), FW'(1));
        chk("hold_win", ifc.win_flat, pw);
        chk("hold_last", FW'(ifc.out_last), FW'(pl));
      end
      if (ifc.out_valid && !ifc.out_ready) begin
        chk("in_ready_stall", FW'(ifc.in_ready), '0);
        pst = 1'b1;
        pw  = ifc.win_flat;
        pl  = ifc.out_last;
      end else begin
        pst = 1'b0;
      end
      if (ifc.out_valid && ifc.out_ready) begin
        got_q.push_back(exp_t'{win: ifc.win_flat, last: ifc.out_last});
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_window actual=%0h required=none",
                   ifc.win_flat);
        end else begin
          e = exp_q.pop_front();
          chk("win", ifc.win_flat, e.win);
          chk("last", FW'(ifc.out_last), FW'(e.last));
        end
      end
    end
  end

  task automatic send_px(input int v, input bit sof);
    int n;
    bit ok;
    n = 0;
    ifc.in_pixel = DW'(v);
    ifc.in_valid = 1'b1;
    ifc.in_sof   = sof;
    forever begin
      @(negedge clk);
      ok = ifc.in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 1000) begin
        n_chk++;
        $display("FAIL accept_timeout actual=%0d required=accept", n);
        break;
      end
    end
  endtask

  task automatic idle();
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input int base, input int npix);
    int r;
    int c;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / W;
      c = idx % W;
      if (r >= 2 && c >= 2)
        exp_q.push_back(exp_t'{win: model(base, r, c),
                               last: (r == H-1 && c == W-1)});
      send_px(base + idx, idx == 0);
    end
    idle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", FW'(exp_q.size()), '0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    ifc.in_pixel = '0;
    ifc.in_valid = 1'b0;
    ifc.in_sof   = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", FW'(ifc.out_valid), '0);
    chk("rst_last", FW'(ifc.out_last), '0);
    chk("rst_win", ifc.win_flat, '0);
    chk("rst_in_ready", FW'(ifc.in_ready), FW'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    got_q.delete();
    send_frame(0, W*H);
    drain();
    chk("f1_count", FW'(got_q.size()), FW'(6));
    chk("f1_first", got_q[0].win, pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("f1_first_last", FW'(got_q[0].last), '0);
    chk("f1_final", got_q[5].win, pk(7, 8, 9, 12, 13, 14, 17, 18, 19));
    chk("f1_final_last", FW'(got_q[5].last), FW'(1));
    chk("mac_sum", FW'(sum9(got_q[0].win)), FW'(54));

    rnd_ready = 1'b1;
    got_q.delete();
    send_frame(0, W*H);
    drain();
    rnd_ready = 1'b0;
    chk("rnd_count", FW'(got_q.size()), FW'(6));

    got_q.delete();
    send_frame(0, W*H);
    send_frame(100, W*H);
    drain();
    chk("f2_count", FW'(got_q.size()), FW'(12));
    chk("f2_first", got_q[6].win,
        pk(100, 101, 102, 105, 106, 107, 110, 111, 112));

    got_q.delete();
    send_frame(0, 8);
    send_frame(200, W*H);
    drain();
    chk("sof_count", FW'(got_q.size()), FW'(6));
    chk("sof_first", got_q[0].win,
        pk(200, 201, 202, 205, 206, 207, 210, 211, 212));

    for (int idx = 0; idx < 14; idx++) begin
      if (idx / W >= 2 && idx % W >= 2)
        exp_q.push_back(exp_t'{win: model(0, idx / W, idx % W),
                               last: 1'b0});
      send_px(idx, idx == 0);
    end
    idle();
    chk("pre_rst_valid", FW'(ifc.out_valid), FW'(1));
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", FW'(ifc.out_valid), '0);
    chk("arst_last", FW'(ifc.out_last), '0);
    chk("arst_win", ifc.win_flat, '0);
    exp_q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    got_q.delete();
    send_frame(0, W*H);
    drain();
    chk("post_rst_count", FW'(got_q.size()), FW'(6));
    chk("post_rst_first", got_q[0].win, pk(0, 1, 2, 5, 6, 7, 10, 11, 12));
    chk("post_rst_final_last", FW'(got_q[5].last), FW'(1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
